// File: rtl/riscv_pkg.sv
// Shared RV32I data-memory types: Funct3 access codes, fault causes, FSM states,
// plus the prioritised fault classifier used by the data memory.
package riscv_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    typedef enum logic [1:0] {
        DM_FAULT_NONE     = 2'b00,
        DM_FAULT_MISALIGN = 2'b01,
        DM_FAULT_RANGE    = 2'b10,
        DM_FAULT_ILLEGAL  = 2'b11
    } dm_fault_e;

    typedef enum logic [1:0] {
        DM_ST_INIT  = 2'b00,
        DM_ST_RUN   = 2'b01,
        DM_ST_FAULT = 2'b10
    } dm_state_e;

    // Illegal control outranks out-of-range, which outranks misalignment.
    function automatic dm_fault_e dm_fault_cause(
        input logic       wr,
        input logic       rd,
        input logic [2:0] ctrl,
        input logic       hi_nz,
        input logic [1:0] lane
    );
        logic st_ok;
        logic ld_ok;
        logic mis;
        dm_fault_e cause;
        st_ok = (ctrl == DM_B) || (ctrl == DM_H) || (ctrl == DM_W);
        ld_ok = st_ok || (ctrl == DM_BU) || (ctrl == DM_HU);
        mis   = ((ctrl[1:0] == 2'b01) && lane[0]) || ((ctrl == DM_W) && (lane != 2'b00));
        if ((wr && rd) || (wr && !st_ok) || (rd && !ld_ok)) begin
            cause = DM_FAULT_ILLEGAL;
        end else if (hi_nz) begin
            cause = DM_FAULT_RANGE;
        end else if (mis) begin
            cause = DM_FAULT_MISALIGN;
        end else begin
            cause = DM_FAULT_NONE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Datapath-to-data-memory bus: address/data/control in, load data and status out.
interface data_memory_if;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic        DMRd;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
    logic        Ready;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic [31:0] FaultAddr;

    modport master (
        output Address, DataWr, DMWr, DMRd, DMCtrl,
        input  DataRd, Ready, Fault, FaultCause, FaultAddr
    );

    modport slave (
        input  Address, DataWr, DMWr, DMRd, DMCtrl,
        output DataRd, Ready, Fault, FaultCause, FaultAddr
    );
endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// sign- or zero-extended load extraction from the raw array word.
module dm_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the raw word.
    always_comb begin
        byte_s = rword_i[{lane_i, 3'b000} +: 8];
        half_s = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Store data is replicated so every enabled lane already holds the right bits.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (ctrl_i)
            DM_B: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            DM_H: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            DM_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
        endcase
    end

    // Load extension.
    always_comb begin
        rdata_o = 32'h0000_0000;
        case (ctrl_i)
            DM_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
            DM_H:    rdata_o = {{16{half_s[15]}}, half_s};
            DM_W:    rdata_o = rword_i;
            DM_BU:   rdata_o = {24'h00_0000, byte_s};
            DM_HU:   rdata_o = {16'h0000, half_s};
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// RV32I data memory: word array with byte-lane stores, post-reset clear
// sequence and a sticky first-fault latch that halts the pipeline.
module data_memory
    import riscv_pkg::*;
#(
    parameter int DEPTH = 1024
)
(
    input logic         clk,
    input logic         rst,
    data_memory_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    dm_state_e   state_q;
    logic [AW-1:0] clr_idx_q;
    logic        ready_q;
    logic        fault_q;
    dm_fault_e   cause_q;
    logic [31:0] fault_addr_q;

    logic        access_s;
    logic        fault_s;
    dm_fault_e   cause_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0] rword_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_s;
    logic        mem_we_s;
    logic [AW-1:0] mem_idx_s;
    logic [3:0]  mem_be_s;
    logic [31:0] mem_wdata_s;

    assign word_idx_s = bus.Address[AW+1:2];
    assign rword_s    = mem_q[word_idx_s];
    assign access_s   = bus.DMWr | bus.DMRd;
    assign cause_s    = dm_fault_cause(bus.DMWr, bus.DMRd, bus.DMCtrl,
                                       |bus.Address[31:AW+2], bus.Address[1:0]);
    assign fault_s    = access_s && (cause_s != DM_FAULT_NONE);

    dm_lane_align u_align (
        .ctrl_i  (bus.DMCtrl),
        .lane_i  (bus.Address[1:0]),
        .wdata_i (bus.DataWr),
        .rword_i (rword_s),
        .be_o    (be_s),
        .wdata_o (wdata_s),
        .rdata_o (rdata_s)
    );

    // Array write port is shared between the clear sweep and clean stores.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = word_idx_s;
        mem_be_s    = be_s;
        mem_wdata_s = wdata_s;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == DM_ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = clr_idx_q;
            mem_be_s    = 4'b1111;
            mem_wdata_s = 32'h0000_0000;
        end else if (state_q == DM_ST_RUN) begin
            mem_we_s = bus.DMWr && !fault_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Byte-lane write into the array.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be_s[i]) begin
                    mem_q[mem_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with the clear counter and the sticky fault latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DM_ST_INIT;
            clr_idx_q    <= '0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            cause_q      <= DM_FAULT_NONE;
            fault_addr_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                DM_ST_INIT: begin
                    clr_idx_q <= clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_q <= DM_ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                DM_ST_RUN: begin
                    if (fault_s) begin
                        state_q      <= DM_ST_FAULT;
                        ready_q      <= 1'b0;
                        fault_q      <= 1'b1;
                        cause_q      <= cause_s;
                        fault_addr_q <= bus.Address;
                    end
                end
                DM_ST_FAULT: begin
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q   <= DM_ST_INIT;
                    clr_idx_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Loads return data only for a clean access while running.
    always_comb begin
        if ((state_q == DM_ST_RUN) && bus.DMRd && !fault_s) begin
            bus.DataRd = rdata_s;
        end else begin
            bus.DataRd = 32'h0000_0000;
        end
    end

    assign bus.Ready      = ready_q;
    assign bus.Fault      = fault_q;
    assign bus.FaultCause = cause_q;
    assign bus.FaultAddr  = fault_addr_q;

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable RV32I data memory that sits directly downstream of the control unit and ALU. It consumes `DMWr`/`DMCtrl` from the control unit, the ALU result as address and rs2 as store data. It returns sign- or zero-extended load data to the register-write mux. It also owns a post-reset clear sequence and a sticky access-fault latch, which the top level uses to stall and halt the PC.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `Address`  in  32  byte address (ALU result).
- `DataWr`  in  32  store data (rs2).
- `DMWr`  in  1  store request.
- `DMRd`  in  1  load request (datapath asserts when `RUDataWrSrc` = 01).
- `DMCtrl`  in  3  access type, equal to Funct3.
- `DataRd`  out  32  load result, combinational.
- `Ready`  out  1  high when accesses are accepted; the top level gates PC update with it.
- `Fault`  out  1  sticky access fault.
- `FaultCause`  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal control.
- `FaultAddr`  out  32  `Address` of the first faulting access.

## Operation
- States:
  - `INIT`: clears the array one word per cycle using index counter `ClrIdx`.
  - `RUN`: normal operation.
  - `FAULT`: halted.
- Transitions:
  - `rst` → `INIT` with `ClrIdx` = 0.
  - `INIT` → `RUN` on the edge where `ClrIdx` = DEPTH-1 is written.
  - `RUN` → `FAULT` on the edge where a faulting access is presented.
  - `FAULT` leaves only on `rst`.
- Reset values: `Ready` 0, `Fault` 0, `FaultCause` 00, `FaultAddr` 0, `ClrIdx` 0. Array contents are undefined until `INIT` completes.
- `Ready` = 1 only in `RUN`.
- Word index = `Address`[log2(DEPTH)+1:2]. Byte lane = `Address`[1:0].
- DMCtrl encoding:
  - Stores: 000 SB, 001 SH, 010 SW.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Access active when `DMWr` | `DMRd`. Inactive cycles are never checked.
- Fault checks, in priority order (highest first):
  1. Illegal control: `DMWr` & `DMRd` both high, or the `DMCtrl` code is not listed above for that direction.
  2. Out of range: `Address`[31:log2(DEPTH)+2] ≠ 0.
  3. Misaligned: halfword with `Address`[0] = 1, or word with `Address`[1:0] ≠ 00.
- Stores write on the rising edge only when in `RUN` and the access is fault-free.
  - SB writes `DataWr`[7:0] into lane `Address`[1:0].
  - SH writes `DataWr`[15:0] into lanes {`Address`[1],0} and {`Address`[1],1}.
  - SW writes all four lanes.
  - Unselected lanes are preserved.
- Loads are combinational from the addressed word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - `DataRd` = 0 when not in `RUN`, when no load is active, or when the current access faults.
- Fault latch captures `FaultCause` and `FaultAddr` once. Later faults never overwrite it.

## Timing
- Load latency: 0 cycles (same-cycle combinational read).
- Store latency: visible to a load in the cycle after the write edge.
- Store followed by a load to the same word in the next cycle returns the new data. No internal bypass is needed.
- `Ready` rises exactly DEPTH cycles after the first cycle with `rst` low.
- `Fault`, `FaultCause`, `FaultAddr` update on the edge that samples the faulting access and are visible the next cycle. `Ready` falls at the same edge.
- A faulting store performs no partial write.
- `rst` asserted mid-`INIT` or in `FAULT`: next state `INIT`, `ClrIdx` = 0, fault fields cleared.
- `rst` asserted concurrently with a store: the store is dropped.

## Structure
- Shared package `riscv_pkg`:
  - `dm_ctrl_e` (Funct3 load/store codes).
  - `dm_fault_e` (the 2-bit cause codes).
  - `dm_state_e` (`INIT`, `RUN`, `FAULT`).
- Sub-module `dm_lane_align` (combinational):
  - Inputs: `DMCtrl`, `Address`[1:0], `DataWr`, raw read word.
  - Outputs: 4-bit byte enable, lane-shifted write word, extended load result.
- Top module holds the array, the FSM, `ClrIdx`, the fault checks and the fault latch.

## Test plan
- Reset with DEPTH=16: `Ready` is 0 for cycles 0–15 after `rst` drops and 1 at cycle 16. LW from addresses 0x00–0x3C all return 0.
- SW 0x8000_7FF1 to 0x10; then LB 0x10 → 0xFFFF_FFF1, LBU 0x10 → 0x0000_00F1, LH 0x12 → 0xFFFF_8000, LHU 0x12 → 0x0000_8000.
- SW 0xAABBCCDD to 0x20; then SB 0x11 to 0x23 and SH 0x2233 to 0x20; LW 0x20 → 0x11BB2233.
- SW to 0x22: `Fault` = 1 and `FaultCause` = 01 next cycle, `FaultAddr` = 0x22, word 0x20 unchanged, `Ready` = 0. A following SB with `DMCtrl` = 011 does not alter `FaultCause` or `FaultAddr`.
- LW from 0x40 (DEPTH=16) → `FaultCause` 10. Separately, `DMWr` and `DMRd` both high at 0x41 → `FaultCause` 11, since illegal control outranks the other checks.
- `rst` pulsed in `FAULT` and again at cycle 5 of `INIT`: fault fields return to 0, and `Ready` rises 16 cycles after the last `rst` low.
